// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the 8-bit computer control sequencer.
//   - opcode values (IR[7:4])
//   - FSM state encoding
//   - A-register source select codes
//   - branch condition codes produced by the instruction decoder
package ctrl_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [1:0] ASRC_MEM  = 2'd0;
    localparam logic [1:0] ASRC_ALU  = 2'd1;
    localparam logic [1:0] ASRC_OPND = 2'd2;

    typedef enum logic [1:0] {
        COND_NONE   = 2'd0,
        COND_ALWAYS = 2'd1,
        COND_CARRY  = 2'd2,
        COND_ZERO   = 2'd3
    } cond_t;

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// instr_decoder: combinational classification of an opcode.
// Ports:
//   opcode    in  4  IR[7:4]
//   is_2byte  out 1  instruction carries an operand byte
//   is_jump   out 1  JMP/JC/JZ
//   cond      out 2  branch condition (COND_NONE for non-jumps)
//   illegal   out 1  undefined opcode (0x9..0xD)
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_2byte,
    output logic             is_jump,
    output cond_t            cond,
    output logic             illegal
);

    // Opcode classification table
    always_comb begin
        is_2byte = 1'b0;
        is_jump  = 1'b0;
        cond     = COND_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_NOP, OP_OUT, OP_HLT: begin
                is_2byte = 1'b0;
            end
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI: begin
                is_2byte = 1'b1;
            end
            OP_JMP: begin
                is_2byte = 1'b1;
                is_jump  = 1'b1;
                cond     = COND_ALWAYS;
            end
            OP_JC: begin
                is_2byte = 1'b1;
                is_jump  = 1'b1;
                cond     = COND_CARRY;
            end
            OP_JZ: begin
                is_2byte = 1'b1;
                is_jump  = 1'b1;
                cond     = COND_ZERO;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute controller for the 8-bit computer.
// Owns the FSM, the opcode register, the operand register and the carry/zero flags.
// All strobes are decoded from registered state; in FETCH the go condition
// (run | step) additionally gates ir_we/pc_hold.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   run, step           free-run level / single-instruction pulse
//   pc_addr             current PC value from the PC block
//   mem_rdata           memory read data for mem_addr
//   alu_carry, alu_zero ALU status for A op mem_rdata
//   mem_addr, mem_we    memory address / write strobe
//   ir_we, a_we, a_src  IR load, A load and A source select
//   alu_sub, out_we     ALU subtract select, output register load
//   pc_hold, pc_load    PC hold (0 = increment) / PC load (overrides hold)
//   jump_addr           PC load value
//   halted, illegal     HALT state indicator / undefined opcode pulse
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              ir_we,
    output logic              a_we,
    output logic [1:0]        a_src,
    output logic              alu_sub,
    output logic              out_we,
    output logic              pc_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] jump_addr,
    output logic              halted,
    output logic              illegal
);

    state_t             state_r;
    state_t             state_nxt_s;
    // Only the opcode field of the instruction byte is ever consulted.
    logic [OPC_W-1:0]   opcode_r;
    logic [ADDR_W-1:0]  operand_r;
    logic               carry_r;
    logic               zero_r;
    logic               flag_we_s;
    logic               go_s;
    logic               cond_met_s;

    logic               dec_is_2byte_s;
    logic               dec_is_jump_s;
    cond_t              dec_cond_s;
    logic               dec_illegal_s;

    instr_decoder u_dec (
        .opcode   (opcode_r),
        .is_2byte (dec_is_2byte_s),
        .is_jump  (dec_is_jump_s),
        .cond     (dec_cond_s),
        .illegal  (dec_illegal_s)
    );

    assign go_s = run | step;

    // Branch condition evaluation against the registered flags
    always_comb begin
        cond_met_s = 1'b0;
        case (dec_cond_s)
            COND_ALWAYS: cond_met_s = 1'b1;
            COND_CARRY:  cond_met_s = carry_r;
            COND_ZERO:   cond_met_s = zero_r;
            default:     cond_met_s = 1'b0;
        endcase
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt_s = state_r;
        mem_addr    = pc_addr;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        a_we        = 1'b0;
        a_src       = ASRC_MEM;
        alu_sub     = 1'b0;
        out_we      = 1'b0;
        pc_hold     = 1'b1;
        pc_load     = 1'b0;
        jump_addr   = operand_r;
        halted      = 1'b0;
        illegal     = 1'b0;
        flag_we_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                // The PC block has no reset of its own; force it to 0 here.
                pc_load     = 1'b1;
                jump_addr   = {ADDR_W{1'b0}};
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (go_s) begin
                    ir_we       = 1'b1;
                    pc_hold     = 1'b0;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal_s) begin
                    illegal = 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else if (opcode_r == OP_HLT) begin
                    state_nxt_s = ST_HALT;
                end else if (dec_is_2byte_s) begin
                    state_nxt_s = ST_OPERAND;
                end else begin
                    out_we      = (opcode_r == OP_OUT);
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_OPERAND: begin
                pc_hold     = 1'b0;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                mem_addr    = operand_r;
                state_nxt_s = ST_FETCH;
                if (dec_is_jump_s) begin
                    pc_load = cond_met_s;
                end else begin
                    case (opcode_r)
                        OP_LDA: begin
                            a_we  = 1'b1;
                            a_src = ASRC_MEM;
                        end
                        OP_ADD: begin
                            a_we      = 1'b1;
                            a_src     = ASRC_ALU;
                            flag_we_s = 1'b1;
                        end
                        OP_SUB: begin
                            a_we      = 1'b1;
                            a_src     = ASRC_ALU;
                            alu_sub   = 1'b1;
                            flag_we_s = 1'b1;
                        end
                        OP_STA: begin
                            mem_we = 1'b1;
                        end
                        OP_LDI: begin
                            a_we  = 1'b1;
                            a_src = ASRC_OPND;
                        end
                        default: begin
                            a_we = 1'b0;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                halted      = 1'b1;
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Opcode, operand and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_r  <= {OPC_W{1'b0}};
            operand_r <= {ADDR_W{1'b0}};
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            if (ir_we) begin
                opcode_r <= mem_rdata[DATA_W-1 -: OPC_W];
            end
            if (state_r == ST_OPERAND) begin
                operand_r <= mem_rdata[ADDR_W-1:0];
            end
            if (flag_we_s) begin
                carry_r <= alu_carry;
                zero_r  <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: surrounding PC block, memory, A/ALU/OUT datapath,
// an instruction-level reference model and directed programs.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [7:0] pc_addr;
    logic [7:0] mem_rdata;
    logic       alu_carry, alu_zero;
    logic [7:0] mem_addr, jump_addr;
    logic       mem_we, ir_we, a_we, alu_sub, out_we, pc_hold, pc_load, halted, illegal;
    logic [1:0] a_src;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .pc_addr(pc_addr),
        .mem_rdata(mem_rdata), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .mem_addr(mem_addr), .mem_we(mem_we), .ir_we(ir_we), .a_we(a_we),
        .a_src(a_src), .alu_sub(alu_sub), .out_we(out_we), .pc_hold(pc_hold),
        .pc_load(pc_load), .jump_addr(jump_addr), .halted(halted), .illegal(illegal)
    );

    // ---------------- environment: PC block, memory, A/ALU/OUT ----------------
    logic [7:0] mem  [256];
    logic [7:0] prog [256];
    logic       load = 1'b0;
    logic [7:0] pc_env = 8'h5A;
    logic [7:0] a_env = 8'h00;
    logic [7:0] out_env = 8'h00;
    int         illegal_cnt = 0;
    logic [8:0] alu_res;

    assign pc_addr   = pc_env;
    assign mem_rdata = mem[mem_addr];
    assign alu_res   = alu_sub ? ({1'b0, a_env} - {1'b0, mem_rdata})
                               : ({1'b0, a_env} + {1'b0, mem_rdata});
    assign alu_carry = alu_res[8];
    assign alu_zero  = (alu_res[7:0] == 8'h00);

    always @(posedge clk) begin
        if (pc_load) pc_env <= jump_addr;
        else if (!pc_hold) pc_env <= pc_env + 8'd1;
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (mem_we) begin
            mem[mem_addr] <= a_env;
        end
        if (a_we) begin
            case (a_src)
                2'd0: a_env <= mem_rdata;
                2'd1: a_env <= alu_res[7:0];
                2'd2: a_env <= jump_addr;
                default: a_env <= a_env;
            endcase
        end
        if (out_we) out_env <= a_env;
        if (illegal) illegal_cnt <= illegal_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic [7:0] mem_addr;
        logic [7:0] jump;
        logic       mem_we, ir_we, a_we;
        logic [1:0] a_src;
        logic       alu_sub, out_we, pc_hold, pc_load, halted, illegal;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mpc = 8'h00;
    logic [7:0] ma = 8'h00;
    logic [7:0] m_op = 8'h00;
    logic       mc = 1'b0, mz = 1'b0, m_halt = 1'b0, init_pend = 1'b1;

    function automatic exp_t rec_base(input logic [7:0] addr);
        exp_t e;
        e = '0;
        e.mem_addr = addr;
        e.jump     = m_op;
        e.pc_hold  = 1'b1;
        return e;
    endfunction

    // Expand one instruction at mpc into its per-cycle output sequence and apply
    // its architectural effect (A, flags, next PC) to the model.
    task automatic build_instr();
        exp_t e;
        logic [7:0] pc1, opnd, m;
        logic [8:0] r;
        logic [3:0] op;
        logic [7:0] ir;
        ir  = mem[mpc];
        op  = ir[7:4];
        pc1 = mpc + 8'd1;
        e = rec_base(mpc); e.ir_we = 1'b1; e.pc_hold = 1'b0; q.push_back(e);
        e = rec_base(pc1);
        e.out_we  = (op == 4'hE);
        e.illegal = (op >= 4'h9) && (op <= 4'hD);
        q.push_back(e);
        if (op == 4'hF) begin
            m_halt = 1'b1;
            mpc    = pc1;
        end else if (op >= 4'h1 && op <= 4'h8) begin
            opnd = mem[pc1];
            e = rec_base(pc1); e.pc_hold = 1'b0; q.push_back(e);
            m_op = opnd;
            e = rec_base(opnd);
            m = mem[opnd];
            mpc = pc1 + 8'd1;
            case (op)
                4'h1: begin e.a_we = 1'b1; e.a_src = 2'd0; ma = m; end
                4'h2: begin
                    e.a_we = 1'b1; e.a_src = 2'd1;
                    r = {1'b0, ma} + {1'b0, m};
                    mc = r[8]; mz = (r[7:0] == 8'h00); ma = r[7:0];
                end
                4'h3: begin
                    e.a_we = 1'b1; e.a_src = 2'd1; e.alu_sub = 1'b1;
                    r = {1'b0, ma} - {1'b0, m};
                    mc = r[8]; mz = (r[7:0] == 8'h00); ma = r[7:0];
                end
                4'h4: e.mem_we = 1'b1;
                4'h5: begin e.a_we = 1'b1; e.a_src = 2'd2; ma = opnd; end
                4'h6: begin e.pc_load = 1'b1; mpc = opnd; end
                4'h7: if (mc) begin e.pc_load = 1'b1; mpc = opnd; end
                4'h8: if (mz) begin e.pc_load = 1'b1; mpc = opnd; end
                default: ;
            endcase
            q.push_back(e);
        end else begin
            mpc = pc1;
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_op = 8'h00; mc = 1'b0; mz = 1'b0; m_halt = 1'b0; init_pend = 1'b1;
            e = rec_base(pc_env); e.pc_load = 1'b1; e.jump = 8'h00;
        end else if (init_pend) begin
            e = rec_base(pc_env); e.pc_load = 1'b1; e.jump = 8'h00;
            init_pend = 1'b0;
            mpc = 8'h00;
        end else if (q.size() != 0) begin
            e = q.pop_front();
        end else begin
            chk("pc_at_boundary", {8'h00, pc_env}, {8'h00, mpc});
            chk("acc_at_boundary", {8'h00, a_env}, {8'h00, ma});
            if (m_halt) begin
                e = rec_base(mpc); e.halted = 1'b1;
            end else if (run | step) begin
                build_instr();
                e = q.pop_front();
            end else begin
                e = rec_base(mpc);
            end
        end
        chk("mem_addr", {8'h00, mem_addr}, {8'h00, e.mem_addr});
        chk("jump_addr", {8'h00, jump_addr}, {8'h00, e.jump});
        chk("strobes",
            {5'd0, mem_we, ir_we, a_we, a_src, alu_sub, out_we, pc_hold, pc_load, halted, illegal},
            {5'd0, e.mem_we, e.ir_we, e.a_we, e.a_src, e.alu_sub, e.out_we, e.pc_hold,
             e.pc_load, e.halted, e.illegal});
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    // Reset with program load; returns 1 time unit after the edge that ends reset,
    // so the next falling edge is cycle 0 (INIT).
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic to_cycle(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {15'd0, halted}, 16'd1);
    endtask

    task automatic pulse_step();
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int ill0, n;
        logic seen;

        // 1: LDI 7; OUT; HLT
        clear_prog();
        prog[0] = 8'h51; prog[1] = 8'h07; prog[2] = 8'hE0; prog[3] = 8'hF0;
        run = 1'b1;
        do_reset();
        to_cycle(0);
        chk("t1_init_pc_load", {15'd0, pc_load}, 16'd1);
        chk("t1_init_jump", {8'h00, jump_addr}, 16'h0000);
        to_cycle(4);
        chk("t1_c4_a_we", {14'd0, a_we, 1'b0}, 16'h0002);
        chk("t1_c4_a_src", {14'd0, a_src}, 16'h0002);
        to_cycle(2);
        chk("t1_c6_out_we", {15'd0, out_we}, 16'd1);
        chk("t1_c6_pc", {8'h00, pc_env}, 16'h0003);
        wait_halt(20);
        chk("t1_out_reg", {8'h00, out_env}, 16'h0007);

        // 2+3: LDI FF; ADD [20]=01 -> C=1 Z=1; JC 40; LDI 01; ADD [21]=01; JZ 10 (not taken);
        //      illegal A0 as NOP; HLT
        clear_prog();
        prog[8'h00] = 8'h50; prog[8'h01] = 8'hFF;
        prog[8'h02] = 8'h20; prog[8'h03] = 8'h20;
        prog[8'h04] = 8'h70; prog[8'h05] = 8'h40;
        prog[8'h20] = 8'h01; prog[8'h21] = 8'h01;
        prog[8'h40] = 8'h50; prog[8'h41] = 8'h01;
        prog[8'h42] = 8'h20; prog[8'h43] = 8'h21;
        prog[8'h44] = 8'h80; prog[8'h45] = 8'h10;
        prog[8'h46] = 8'hA0; prog[8'h47] = 8'hF0;
        ill0 = illegal_cnt;
        do_reset();
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (ir_we && mem_addr == 8'h40) seen = 1'b1;
            n++;
        end
        chk("t2_fetch_at_40", {15'd0, seen}, 16'd1);
        chk("t2_acc_after_add", {8'h00, a_env}, 16'h0000);
        wait_halt(60);
        chk("t3_final_pc", {8'h00, pc_env}, 16'h0048);
        chk("t3_final_acc", {8'h00, a_env}, 16'h0002);
        chk("t5_illegal_count", 16'(illegal_cnt - ill0), 16'd1);

        // 4: single stepping
        clear_prog();
        prog[0] = 8'h50; prog[1] = 8'h03; prog[2] = 8'hE0; prog[3] = 8'h00; prog[4] = 8'hF0;
        run = 1'b0;
        do_reset();
        to_cycle(6);
        chk("t4_idle_pc", {8'h00, pc_env}, 16'h0000);
        chk("t4_idle_hold", {15'd0, pc_hold}, 16'd1);
        pulse_step();
        to_cycle(8);
        chk("t4_step1_pc", {8'h00, pc_env}, 16'h0002);
        chk("t4_step1_acc", {8'h00, a_env}, 16'h0003);
        pulse_step();
        to_cycle(6);
        chk("t4_step2_pc", {8'h00, pc_env}, 16'h0003);
        chk("t4_step2_out", {8'h00, out_env}, 16'h0003);
        @(posedge clk); #1;
        run = 1'b1; step = 1'b1;
        @(posedge clk); #1;
        run = 1'b0; step = 1'b0;
        to_cycle(6);
        chk("t4_runstep_pc", {8'h00, pc_env}, 16'h0004);
        chk("t4_runstep_not_halted", {15'd0, halted}, 16'd0);
        run = 1'b1;
        wait_halt(10);
        chk("t4_halt_pc", {8'h00, pc_env}, 16'h0005);

        // 5: HLT at 05 stays halted with PC 06
        clear_prog();
        prog[5] = 8'hF0;
        do_reset();
        wait_halt(30);
        to_cycle(20);
        chk("t5_halt_pc", {8'h00, pc_env}, 16'h0006);
        chk("t5_still_halted", {15'd0, halted}, 16'd1);

        // 6: reset during EXEC of STA
        clear_prog();
        prog[0] = 8'h50; prog[1] = 8'hAA; prog[2] = 8'h40; prog[3] = 8'h30; prog[4] = 8'hF0;
        do_reset();
        to_cycle(8);
        chk("t6_sta_mem_we", {15'd0, mem_we}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mem_we", {15'd0, mem_we}, 16'd0);
        chk("t6_async_pc_load", {15'd0, pc_load}, 16'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("t6_no_write", {8'h00, mem[8'h30]}, 16'h0000);
        rst = 1'b0;
        to_cycle(0);
        chk("t6_init_pc_load", {15'd0, pc_load}, 16'd1);
        chk("t6_init_jump", {8'h00, jump_addr}, 16'h0000);
        to_cycle(1);
        chk("t6_fetch_addr", {8'h00, mem_addr}, 16'h0000);
        chk("t6_fetch_ir_we", {15'd0, ir_we}, 16'd1);
        wait_halt(30);
        chk("t6_sta_written", {8'h00, mem[8'h30]}, 16'h00AA);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
